grant_decoder: RTL
==================

// Module: grant_decoder
// PURPOSE
//  Consumer end of the priority-encoder interface. Takes an encoded request
//   (index + zero flag) via a valid/ready handshake and decodes it to a one-hot grant.
//  Holds the grant for a bounded number of cycles, then releases it.
//  Feeds the next rotating start priority back to the encoder, one past the last winner.
//  Sits between the request priority encoder and the granted resource.
// PARAMETERS
//  N     8  number of requesters; width of the one-hot grant
//  W     3  index width; must satisfy 2**W == N
//  HOLD  4  maximum grant length in cycles; HOLD >= 1
// PORTS
//  clk          in   1  rising-edge clock; the only clock
//  rst_n        in   1  synchronous, active-low reset
//  idx_in       in   W  encoded winning index from the encoder
//  zero_in      in   1  encoder reports no request active
//  req_valid    in   1  idx_in/zero_in valid this cycle
//  req_ready    out  1  decoder can accept a request
//  release_in   in   1  resource done early; drop the grant
//  grant        out  N  one-hot grant; all zero when not granting
//  grant_valid  out  1  grant is asserted
//  done         out  1  one-cycle pulse when a grant ends
//  pri_out      out  W  start priority for the encoder's next search
// BEHAVIOUR
//  Reset (rst_n=0 at a clock edge), synchronous, overrides everything, including mid-grant:
//   state=IDLE, grant=0, grant_valid=0, done=0, pri_out=0, req_ready=1, hold counter=0.
//  All outputs are registered except req_ready, which is decoded from state (1 only in IDLE).
//  FSM states: IDLE, GRANT, RELEASE.
//  IDLE -- accept on the edge where req_valid and req_ready are both 1:
//   zero_in=1: no grant; stay IDLE; pri_out unchanged; idx_in ignored.
//   zero_in=0: latch idx_in; go to GRANT. From the next cycle, grant=1<<idx and
//    grant_valid=1 (latency 1 cycle). Hold counter loads HOLD-1.
//   req_valid=0: stay IDLE.
//  GRANT:
//   Grant stays stable; counter decrements each cycle.
//   Leave for RELEASE when counter==0 or release_in=1 is sampled.
//   If both happen in the same cycle, the grant still ends once, with a single done pulse.
//   Without early release, grant is high for exactly HOLD cycles.
//   release_in is ignored outside GRANT.
//   req_valid is ignored (req_ready=0); the upstream holds its request.
//  RELEASE (one cycle):
//   grant=0, grant_valid=0, done=1.
//   pri_out = (idx+1) mod N, so 7 wraps to 0; arithmetic is W bits with natural wrap.
//   Next state is IDLE, where done returns to 0.
//  pri_out changes only on entry to RELEASE or on reset.
//  Minimum spacing between grants: HOLD+2 cycles, or 3 cycles with release_in.
//  grant is always one-hot or zero; never more than one bit set.
// STRUCTURE
//  Shared package hw5_pkg: N, W, HOLD defaults; state encoding
//   (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2; 2'd3 is illegal and returns to IDLE).
//  One sub-module, onehot_dec: combinational W-to-N decoder with an enable.
//   Instantiated once, driven by the latched index; output registered here.
//  Top level holds the FSM, hold counter, index latch and pri_out register.
// TESTING
//  1. Reset, then idle -> grant=0, grant_valid=0, done=0, pri_out=0, req_ready=1.
//  2. idx_in=5, zero_in=0, req_valid=1 for one edge, release_in=0 (HOLD=4)
//     -> grant=8'b00100000 for 4 cycles; then done=1 for 1 cycle; then pri_out=6.
//  3. idx_in=7 accepted, release_in=1 on the 2nd grant cycle
//     -> grant=8'b10000000 for 2 cycles; done pulse; pri_out=0 (wrap).
//  4. zero_in=1, req_valid=1 -> no grant; no done; pri_out unchanged; req_ready stays 1.
//  5. rst_n=0 on the 2nd grant cycle of idx_in=3 -> next cycle grant=0, done=0,
//     pri_out=0, req_ready=1.
//  6. req_valid held high during GRANT with a new idx_in -> new index ignored until IDLE;
//     then accepted and granted.

Source files
------------

// File: rtl/hw5_pkg.sv
// Shared defaults and state encoding for the grant decoder slice.
package hw5_pkg;
  localparam int N_DEF    = 8;
  localparam int W_DEF    = 3;
  localparam int HOLD_DEF = 4;

  // 2'd3 is unused and recovers to S_IDLE
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
endpackage

// File: rtl/grant_decoder_onehot_dec.sv
// Combinational W-to-N one-hot decoder with enable; all zero when disabled.
module onehot_dec #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/grant_decoder.sv
// Decodes an encoded winner into a held one-hot grant and returns the next
// rotating start priority to the encoder.
module grant_decoder
  import hw5_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W    = W_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] idx_in,
  input  logic         zero_in,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         release_in,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         done,
  output logic [W-1:0] pri_out
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [1:0]    state, nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  idx_q, dec_idx;
  logic [N-1:0]  dec_out;

  assign req_ready = (state == S_IDLE);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (req_valid && !zero_in) nxt = S_GRANT;
      S_GRANT:   if (cnt == '0 || release_in) nxt = S_RELEASE;
      S_RELEASE: nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Decode the incoming index on the accept edge so the grant appears one
  // cycle after acceptance; afterwards the latched index keeps it stable.
  assign dec_idx = (state == S_IDLE) ? idx_in : idx_q;

  onehot_dec #(.N(N), .W(W)) u_dec (
    .idx    (dec_idx),
    .en     (nxt == S_GRANT),
    .onehot (dec_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      done        <= 1'b0;
      pri_out     <= '0;
    end else begin
      state       <= nxt;
      grant       <= dec_out;
      grant_valid <= (nxt == S_GRANT);
      done        <= (nxt == S_RELEASE);
      if (state == S_IDLE && nxt == S_GRANT) begin
        idx_q <= idx_in;
        cnt   <= CW'(HOLD - 1);
      end else if (state == S_GRANT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == S_GRANT && nxt == S_RELEASE) pri_out <= idx_q + 1'b1;
    end
  end
endmodule
